// File: rtl/sprite_anim_render_if.sv
// sprite_anim_render_if: pixel, position, control and sprite ROM signals for one sprite renderer
interface sprite_anim_render_if #(
    parameter int CONV   = 0,
    parameter int W_LOG2 = 3,
    parameter int H_LOG2 = 3,
    parameter int F_LOG2 = 1
);
    logic [9:CONV]                     i_hpos;
    logic [9:CONV]                     i_vpos;
    logic [9:CONV]                     i_xpos;
    logic [9:CONV]                     i_ypos;
    logic                              i_frame_tick;
    logic                              i_run;
    logic                              i_flip;
    logic                              i_dead;
    logic [F_LOG2+H_LOG2+W_LOG2-1:0]   o_rom_addr;
    logic                              i_sprite_color;
    logic                              o_color;
    logic [F_LOG2-1:0]                 o_frame;

    modport master (
        output i_hpos, i_vpos, i_xpos, i_ypos, i_frame_tick, i_run, i_flip, i_dead, i_sprite_color,
        input  o_rom_addr, o_color, o_frame
    );

    modport slave (
        input  i_hpos, i_vpos, i_xpos, i_ypos, i_frame_tick, i_run, i_flip, i_dead, i_sprite_color,
        output o_rom_addr, o_color, o_frame
    );
endinterface

// File: rtl/sprite_anim_render.sv
// sprite_anim_render: positioned, animated, mirrorable, blinking sprite with 1-clk pixel latency
module sprite_anim_render #(
    parameter int CONV       = 0,
    parameter int W_LOG2     = 3,
    parameter int H_LOG2     = 3,
    parameter int F_LOG2     = 1,
    parameter int ANIM_DIV   = 6,
    parameter int BLINK_LOG2 = 3
) (
    input logic                 clk,
    input logic                 rst,
    sprite_anim_render_if.slave bus
);
    localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    logic [9:CONV]           x_off_r;
    logic [9:CONV]           y_off_r;
    logic                    flip_r;
    logic                    dead_r;
    logic                    valid_r;
    logic [DW-1:0]           div_cnt;
    logic [F_LOG2-1:0]       frame_q;
    logic [BLINK_LOG2-1:0]   blink_cnt;
    logic                    in_sprite;
    logic                    blank;
    logic [W_LOG2-1:0]       col;
    logic [H_LOG2-1:0]       row;

    // stage 1: sprite-relative offsets (negative wraps large) and per-pixel controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_off_r <= '0;
            y_off_r <= '0;
            flip_r  <= 1'b0;
            dead_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            x_off_r <= bus.i_hpos - bus.i_xpos;
            y_off_r <= bus.i_vpos - bus.i_ypos;
            flip_r  <= bus.i_flip;
            dead_r  <= bus.i_dead;
            valid_r <= 1'b1;
        end
    end

    // animation: advance one frame every ANIM_DIV running frame ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            frame_q <= '0;
        end else if (bus.i_frame_tick && bus.i_run) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_LAST)
                frame_q <= frame_q + 1'b1;
        end
    end

    // death blink: counts ticks while dead, cleared as soon as dead drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blink_cnt <= '0;
        else if (!bus.i_dead)
            blink_cnt <= '0;
        else if (bus.i_frame_tick)
            blink_cnt <= blink_cnt + 1'b1;
    end

    // hit test, ROM addressing and colour gating from registered state
    always_comb begin
        in_sprite = ~|(x_off_r >> W_LOG2) && ~|(y_off_r >> H_LOG2);
        col       = x_off_r[CONV+W_LOG2-1:CONV] ^ {W_LOG2{flip_r}};
        row       = y_off_r[CONV+H_LOG2-1:CONV];
        blank     = dead_r && blink_cnt[BLINK_LOG2-1];
    end

    assign bus.o_rom_addr = {frame_q, row, col};
    assign bus.o_color    = valid_r && in_sprite && bus.i_sprite_color && !blank;
    assign bus.o_frame    = frame_q;
endmodule

// File: tb/tb_sprite_anim_render.sv
// tb_sprite_anim_render: directed and random checks of sprite_anim_render against a behavioural model
module tb_sprite_anim_render;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    sprite_anim_render_if #(.CONV(0), .W_LOG2(3), .H_LOG2(3), .F_LOG2(1)) bus ();
    sprite_anim_render_if #(.CONV(1), .W_LOG2(4), .H_LOG2(3), .F_LOG2(1)) bus2 ();

    sprite_anim_render #(.CONV(0), .W_LOG2(3), .H_LOG2(3), .F_LOG2(1), .ANIM_DIV(6), .BLINK_LOG2(3))
        dut (.clk(clk), .rst(rst), .bus(bus));
    sprite_anim_render #(.CONV(1), .W_LOG2(4), .H_LOG2(3), .F_LOG2(1), .ANIM_DIV(6), .BLINK_LOG2(3))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    bit rom1 [128];
    bit rom2 [256];
    assign bus.i_sprite_color  = rom1[bus.o_rom_addr];
    assign bus2.i_sprite_color = rom2[bus2.o_rom_addr];

    always #5 clk = ~clk;

    int xpos = 6, ypos = 20, runs = 0, blinks = 0;
    bit run = 0, flip = 0, dead = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int h, input int v, input bit tk);
        int xo, yo, col, ea, fr;
        bit ec;
        @(negedge clk);
        bus.i_hpos = 10'(h);
        bus.i_vpos = 10'(v);
        bus.i_xpos = 10'(xpos);
        bus.i_ypos = 10'(ypos);
        bus.i_frame_tick = tk;
        bus.i_run = run;
        bus.i_flip = flip;
        bus.i_dead = dead;
        @(posedge clk);
        if (!dead) blinks = 0;
        else if (tk) blinks++;
        if (tk && run) runs++;
        #1;
        bus.i_frame_tick = 1'b0;
        xo  = (h - xpos) & 1023;
        yo  = (v - ypos) & 1023;
        col = flip ? 7 - (xo % 8) : xo % 8;
        fr  = (runs / 6) % 2;
        ea  = fr * 64 + (yo % 8) * 8 + col;
        ec  = xo < 8 && yo < 8 && rom1[ea] && !(dead && (blinks % 8) >= 4);
        chk("addr", bus.o_rom_addr, ea);
        chk("color", bus.o_color, ec);
        chk("frame", bus.o_frame, fr);
    endtask

    task automatic step2(input int h, input bit fl);
        int xo, yo, col, ea;
        bit ec;
        @(negedge clk);
        bus2.i_hpos = 9'(h);
        bus2.i_vpos = 9'd52;
        bus2.i_flip = fl;
        @(posedge clk);
        #1;
        xo  = (h - 100) & 511;
        yo  = (52 - 50) & 511;
        col = fl ? 15 - (xo % 16) : xo % 16;
        ea  = (yo % 8) * 16 + col;
        ec  = xo < 16 && yo < 8 && rom2[ea];
        chk("c2_addr", bus2.o_rom_addr, ea);
        chk("c2_color", bus2.o_color, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        foreach (rom1[i]) rom1[i] = 1'b1;
        foreach (rom2[i]) rom2[i] = 1'($urandom_range(0, 1));
        bus.i_hpos = '0; bus.i_vpos = '0; bus.i_xpos = '0; bus.i_ypos = '0;
        bus.i_frame_tick = 0; bus.i_run = 0; bus.i_flip = 0; bus.i_dead = 0;
        bus2.i_hpos = '0; bus2.i_vpos = '0; bus2.i_xpos = 9'd100; bus2.i_ypos = 9'd50;
        bus2.i_frame_tick = 0; bus2.i_run = 0; bus2.i_flip = 0; bus2.i_dead = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_color", bus.o_color, 0);
        chk("rst_frame", bus.o_frame, 0);
        chk("rst_addr", bus.o_rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 19; v <= 29; v++)
            for (int h = 0; h <= 20; h++)
                step(h, v, 0);

        step(9, 22, 0);
        chk("addr_noflip", bus.o_rom_addr, 19);
        flip = 1;
        step(9, 22, 0);
        chk("addr_flip", bus.o_rom_addr, 20);
        flip = 0;

        run = 1;
        for (int i = 1; i <= 12; i++) begin
            step(8, 22, 1);
            if (i == 5) chk("anim_hold5", bus.o_frame, 0);
            if (i == 6) chk("anim_step6", bus.o_frame, 1);
            if (i == 12) chk("anim_wrap12", bus.o_frame, 0);
        end
        repeat (3) step(8, 22, 1);
        run = 0;
        repeat (10) step(8, 22, 1);
        chk("anim_paused", bus.o_frame, 0);
        run = 1;
        repeat (3) step(8, 22, 1);
        chk("anim_resume", bus.o_frame, 1);
        run = 0;

        dead = 1;
        step(8, 22, 0);
        for (int i = 1; i <= 12; i++) begin
            step(8, 22, 1);
            if (i == 3) chk("blink_vis3", bus.o_color, 1);
            if (i == 4) chk("blink_hid4", bus.o_color, 0);
            if (i == 8) chk("blink_vis8", bus.o_color, 1);
        end
        dead = 0;
        step(8, 22, 0);
        chk("blink_clear", bus.o_color, 1);
        dead = 1;
        repeat (4) step(8, 22, 1);
        chk("blink_hid_again", bus.o_color, 0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_color", bus.o_color, 0);
        chk("midrst_frame", bus.o_frame, 0);
        chk("midrst_addr", bus.o_rom_addr, 0);
        runs = 0;
        blinks = 0;
        @(negedge clk);
        rst = 1'b0;
        step(8, 22, 0);
        chk("resume_color", bus.o_color, 1);

        foreach (rom1[i]) rom1[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 400; i++) begin
            int h, v;
            if ($urandom_range(0, 15) == 0) dead = ~dead;
            if ($urandom_range(0, 31) == 0) begin
                xpos = $urandom_range(0, 1023);
                ypos = $urandom_range(0, 1023);
            end
            run  = $urandom_range(0, 3) != 0;
            flip = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end else begin
                h = (xpos + $urandom_range(0, 11) - 2) & 1023;
                v = (ypos + $urandom_range(0, 11) - 2) & 1023;
            end
            step(h, v, $urandom_range(0, 5) == 0);
        end

        for (int h = 95; h <= 120; h++)
            step2(h, 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
